// File: rtl/aud_pwm_seq.sv
// aud_pwm_seq: buffers audio samples in a small FIFO, paces them out at a
// programmable sample period and feeds duty values plus a load strobe to the
// PWM modulator, whose reset is gated by the sequencing state machine.
//
// state | meaning
// IDLE  | stopped, PWM core held in reset, pushes accepted for preload
// PRIME | divider latched, waiting for FIFO occupancy to reach the threshold
// PLAY  | one pop per tick, a tick on an empty FIFO counts an underrun
// DRAIN | playing out what is left, a tick on an empty FIFO returns to IDLE
module aud_pwm_seq #(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  input  logic                enable_i,
  input  logic                soft_rst_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [LVL_W-1:0]    prime_lvl_i,
  input  logic                s_valid_i,
  input  logic [SAMPLE_W-1:0] s_data_i,
  output logic                s_ready_o,
  output logic [SAMPLE_W-1:0] duty_o,
  output logic                duty_load_o,
  output logic                pwm_rstn_o,
  output logic [1:0]          state_o,
  output logic [LVL_W-1:0]    level_o,
  output logic                underrun_o,
  output logic [15:0]         underrun_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    prime_thr;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q;
  logic                duty_load_q;
  logic                pwm_rstn_q;
  logic                underrun_q;
  logic [15:0]         underrun_cnt_q;

  logic push, pop, tick, fifo_empty, running;

  // s_ready deliberately ignores a same-cycle pop to keep the path short
  assign s_ready_o  = (level_q != LVL_FULL) && !soft_rst_i;
  assign push       = s_valid_i && s_ready_o;
  assign fifo_empty = (level_q == '0);
  assign running    = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
  // pacing timer is a down-counter reloaded with the latched divider,
  // so terminal count 0 marks the sample tick
  assign tick       = running && (cnt_q == '0);
  assign pop        = tick && !fifo_empty;
  assign prime_thr  = (prime_lvl_i == '0) ? LVL_W'(1) : prime_lvl_i;

  // Next occupancy and next pacing count
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    cnt_d = tick ? div_q : (cnt_q - DIV_W'(1));
  end

  // Sample storage; occupancy tracks validity so the array needs no reset
  always_ff @(posedge pclk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  // Sequencer FSM with FIFO pointers, pacing counter and registered outputs
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      div_q          <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      duty_load_q    <= 1'b0;
      pwm_rstn_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else if (soft_rst_i) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      div_q          <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      duty_load_q    <= 1'b0;
      pwm_rstn_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      level_q     <= level_d;
      duty_load_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        duty_q   <= mem_q[rd_ptr_q];
      end
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_q <= ST_PRIME;
            div_q   <= div_i;
          end
        end
        ST_PRIME: begin
          if (!enable_i) begin
            state_q <= ST_IDLE;
          end else if (level_q >= prime_thr) begin
            state_q    <= ST_PLAY;
            pwm_rstn_q <= 1'b1;
            cnt_q      <= div_q;
          end
        end
        ST_PLAY: begin
          cnt_q <= cnt_d;
          if (tick && fifo_empty) begin
            underrun_q <= 1'b1;
            if (underrun_cnt_q != 16'hFFFF) begin
              underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
          end
          if (!enable_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_d;
          // running dry wins over a re-enable on the same cycle
          if (tick && fifo_empty) begin
            state_q    <= ST_IDLE;
            pwm_rstn_q <= 1'b0;
          end else if (enable_i) begin
            state_q <= ST_PLAY;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o        = state_q;
  assign level_o        = level_q;
  assign duty_o         = duty_q;
  assign duty_load_o    = duty_load_q;
  assign pwm_rstn_o     = pwm_rstn_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = underrun_cnt_q;

endmodule

// File: tb/tb_aud_pwm_seq.sv
// Testbench for aud_pwm_seq: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model of the sequencer.
module tb_aud_pwm_seq;

  logic        pclk_i, presetn_i, enable_i, soft_rst_i;
  logic [15:0] div_i;
  logic [3:0]  prime_lvl_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic [7:0]  duty_o;
  logic        duty_load_o, pwm_rstn_o;
  logic [1:0]  state_o;
  logic [3:0]  level_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  int n_chk, n_fail;

  aud_pwm_seq dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i), .enable_i(enable_i),
    .soft_rst_i(soft_rst_i), .div_i(div_i), .prime_lvl_i(prime_lvl_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .duty_o(duty_o), .duty_load_o(duty_load_o), .pwm_rstn_o(pwm_rstn_o),
    .state_o(state_o), .level_o(level_o), .underrun_o(underrun_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  // ---------------- behavioural model ----------------
  // states: 0 idle, 1 prime, 2 play, 3 drain; counter counts up 0..div
  logic [7:0]  mq [$];
  int          m_st, m_cnt, m_div, m_sz;
  logic [7:0]  m_duty;
  bit          m_load, m_under, m_tk, m_was_empty;
  logic [15:0] m_ucnt;

  task mreset();
    mq.delete();
    m_st = 0; m_cnt = 0; m_div = 0;
    m_duty = 8'h00; m_load = 0; m_under = 0; m_ucnt = 16'h0000;
  endtask

  always @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i || soft_rst_i) begin
      mreset();
    end else begin
      m_sz = mq.size();
      m_was_empty = (m_sz == 0);
      m_load = 0;
      m_tk = (m_st >= 2) && (m_cnt == m_div);
      if (m_st >= 2) m_cnt = m_tk ? 0 : m_cnt + 1;
      if (m_tk) begin
        if (!m_was_empty) begin
          m_duty = mq.pop_front();
          m_load = 1;
        end else if (m_st == 2) begin
          m_under = 1;
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        end
      end
      case (m_st)
        0: if (enable_i) begin m_st = 1; m_div = int'(div_i); end
        1: if (!enable_i) m_st = 0;
           else if (m_sz >= ((prime_lvl_i == 0) ? 1 : int'(prime_lvl_i))) begin
             m_st = 2; m_cnt = 0;
           end
        2: if (!enable_i) m_st = 3;
        default: if (m_tk && m_was_empty) m_st = 0; else if (enable_i) m_st = 2;
      endcase
      if (s_valid_i && m_sz < 8) mq.push_back(s_data_i);
    end
  end

  function automatic logic [33:0] dut_vec();
    return {state_o, level_o, s_ready_o, duty_o, duty_load_o, pwm_rstn_o,
            underrun_o, underrun_cnt_o};
  endfunction

  function automatic logic [33:0] mdl_vec();
    logic [1:0] st = 2'(m_st);
    logic [3:0] lv = 4'(mq.size());
    logic       rdy = (mq.size() < 8) && !soft_rst_i;
    logic       prn = (m_st >= 2);
    return {st, lv, rdy, m_duty, m_load, prn, m_under, m_ucnt};
  endfunction

  task automatic flush();
    enable_i = 0; s_valid_i = 0; soft_rst_i = 1;
    @(negedge pclk_i);
    soft_rst_i = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    presetn_i = 0; enable_i = 1; s_valid_i = 1; s_data_i = 8'hAA;
    repeat (2) @(negedge pclk_i);
    n_chk++;
    if ({state_o, level_o, pwm_rstn_o, duty_o, duty_load_o, underrun_o, underrun_cnt_o} !== 33'd0) begin
      n_fail++; $display("FAIL rst_hold got=%h exp=0", {state_o, level_o, duty_o, underrun_cnt_o});
    end
    presetn_i = 1; enable_i = 0; s_valid_i = 0;
    @(negedge pclk_i);
    n_chk++; if (state_o !== 2'd0)     begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    n_chk++; if (level_o !== 4'd0)     begin n_fail++; $display("FAIL rst_level got=%0d exp=0", level_o); end
    n_chk++; if (s_ready_o !== 1'b1)   begin n_fail++; $display("FAIL rst_ready got=%b exp=1", s_ready_o); end
    n_chk++; if (pwm_rstn_o !== 1'b0)  begin n_fail++; $display("FAIL rst_pwm got=%b exp=0", pwm_rstn_o); end
    n_chk++; if (duty_o !== 8'h00)     begin n_fail++; $display("FAIL rst_duty got=%h exp=00", duty_o); end
    n_chk++; if (underrun_cnt_o !== 16'h0) begin n_fail++; $display("FAIL rst_ucnt got=%h exp=0", underrun_cnt_o); end
  endtask

  task automatic test_prime_play();
    logic [7:0] exp_d [3];
    int nl, last, t;
    bit saw_prime, done;
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h30;
    nl = 0; last = 0; t = 0; saw_prime = 0; done = 0;
    div_i = 16'd3; prime_lvl_i = 4'd2;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1; s_data_i = exp_d[i];
      @(negedge pclk_i);
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL pp_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    end
    s_valid_i = 0; enable_i = 1;
    while (!done && t < 60) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL pp_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      if (state_o == 2'd1) saw_prime = 1;
      if (duty_load_o) begin
        n_chk++;
        if (nl >= 3 || duty_o !== exp_d[nl]) begin n_fail++; $display("FAIL pp_duty idx=%0d got=%h", nl, duty_o); end
        if (nl > 0) begin
          n_chk++; if (t - last != 4) begin n_fail++; $display("FAIL pp_period got=%0d exp=4", t - last); end
        end
        last = t; nl++;
      end
      if (underrun_o) begin
        done = 1;
        n_chk++; if (underrun_cnt_o !== 16'd1) begin n_fail++; $display("FAIL pp_ucnt got=%0d exp=1", underrun_cnt_o); end
        n_chk++; if (duty_o !== 8'h30) begin n_fail++; $display("FAIL pp_hold got=%h exp=30", duty_o); end
        n_chk++; if (t - last != 4 || nl != 3) begin n_fail++; $display("FAIL pp_under_time gap=%0d loads=%0d exp 4/3", t - last, nl); end
      end
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL pp_timeout got=no_underrun exp=underrun"); end
    n_chk++; if (!saw_prime) begin n_fail++; $display("FAIL pp_prime got=0 exp=1"); end
    flush();
  endtask

  task automatic test_full_fifo();
    int nl, k, t;
    logic [7:0] ev;
    nl = 0; k = 0; t = 0;
    div_i = 16'd0; prime_lvl_i = 4'd8;
    for (int i = 0; i < 9; i++) begin
      s_valid_i = 1; s_data_i = 8'(i);
      if (i == 8) begin
        n_chk++; if (s_ready_o !== 1'b0 || level_o !== 4'd8) begin
          n_fail++; $display("FAIL full_ready got=%b/%0d exp=0/8", s_ready_o, level_o); end
      end
      @(negedge pclk_i);
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL full_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    end
    s_valid_i = 0;
    n_chk++; if (level_o !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", level_o); end
    enable_i = 1;
    while (nl < 14 && t < 40) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL full_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      if (duty_load_o) begin
        ev = (nl < 8) ? 8'(nl) : 8'(8'hA0 + nl - 8);
        n_chk++; if (duty_o !== ev) begin n_fail++; $display("FAIL full_order idx=%0d got=%h exp=%h", nl, duty_o, ev); end
        nl++;
      end
      if (state_o == 2'd2 && k < 6) begin
        s_valid_i = 1; s_data_i = 8'(8'hA0 + k);
        #1 if (s_ready_o) k++;
      end else begin
        s_valid_i = 0;
      end
    end
    n_chk++; if (nl != 14) begin n_fail++; $display("FAIL full_timeout got=%0d loads exp=14", nl); end
    flush();
  endtask

  task automatic test_drain();
    int nl, last, t;
    bit done;
    nl = 0; last = 0; t = 0; done = 0;
    div_i = 16'd2; prime_lvl_i = 4'd3;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1; s_data_i = 8'(8'h41 + i);
      @(negedge pclk_i);
    end
    s_valid_i = 0; enable_i = 1;
    while (state_o != 2'd2 && t < 10) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL dr_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    end
    n_chk++; if (level_o !== 4'd3) begin n_fail++; $display("FAIL dr_level got=%0d exp=3", level_o); end
    enable_i = 0;
    @(negedge pclk_i);
    n_chk++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL dr_state got=%0d exp=3", state_o); end
    t = 0;
    while (!done && t < 30) begin
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL dr_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      if (duty_load_o) begin
        n_chk++; if (duty_o !== 8'(8'h41 + nl)) begin n_fail++; $display("FAIL dr_duty idx=%0d got=%h", nl, duty_o); end
        if (nl > 0) begin
          n_chk++; if (t - last != 3) begin n_fail++; $display("FAIL dr_period got=%0d exp=3", t - last); end
        end
        last = t; nl++;
      end
      if (state_o == 2'd0) begin
        done = 1;
        n_chk++; if (nl != 3 || t - last != 3) begin n_fail++; $display("FAIL dr_idle loads=%0d gap=%0d exp 3/3", nl, t - last); end
        n_chk++; if (underrun_cnt_o !== 16'd0 || underrun_o !== 1'b0) begin n_fail++; $display("FAIL dr_ucnt got=%0d exp=0", underrun_cnt_o); end
        n_chk++; if (pwm_rstn_o !== 1'b0) begin n_fail++; $display("FAIL dr_pwm got=%b exp=0", pwm_rstn_o); end
        n_chk++; if (duty_o !== 8'h43) begin n_fail++; $display("FAIL dr_hold got=%h exp=43", duty_o); end
      end
      @(negedge pclk_i); t++;
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL dr_timeout got=no_idle exp=idle"); end
    flush();
  endtask

  task automatic test_abort_flush();
    int t;
    t = 0;
    div_i = 16'd20; prime_lvl_i = 4'd8; enable_i = 1;
    @(negedge pclk_i);
    n_chk++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL ab_prime got=%0d exp=1", state_o); end
    enable_i = 0;
    @(negedge pclk_i);
    n_chk++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL ab_idle got=%0d exp=0", state_o); end
    prime_lvl_i = 4'd1; s_valid_i = 1; s_data_i = 8'h55;
    @(negedge pclk_i);
    s_valid_i = 0; enable_i = 1;
    while (underrun_cnt_o != 16'd2 && t < 200) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL ab_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    end
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1; s_data_i = 8'(8'hC0 + i);
      @(negedge pclk_i);
    end
    s_valid_i = 0;
    n_chk++; if (level_o !== 4'd5 || underrun_cnt_o !== 16'd2 || state_o !== 2'd2 || duty_o !== 8'h55) begin
      n_fail++; $display("FAIL ab_pre lvl=%0d ucnt=%0d st=%0d duty=%h exp 5/2/2/55", level_o, underrun_cnt_o, state_o, duty_o); end
    soft_rst_i = 1; s_valid_i = 1;
    @(negedge pclk_i);
    soft_rst_i = 0; s_valid_i = 0; enable_i = 0;
    n_chk++; if (level_o !== 4'd0)         begin n_fail++; $display("FAIL ab_level got=%0d exp=0", level_o); end
    n_chk++; if (underrun_cnt_o !== 16'd0) begin n_fail++; $display("FAIL ab_ucnt got=%0d exp=0", underrun_cnt_o); end
    n_chk++; if (duty_o !== 8'h00)         begin n_fail++; $display("FAIL ab_duty got=%h exp=00", duty_o); end
    n_chk++; if (state_o !== 2'd0 || underrun_o !== 1'b0 || pwm_rstn_o !== 1'b0) begin
      n_fail++; $display("FAIL ab_state got=%0d/%b/%b exp=0/0/0", state_o, underrun_o, pwm_rstn_o); end
    @(negedge pclk_i);
  endtask

  task automatic test_div0_saturate();
    int nl, last, t;
    nl = 0; last = 0; t = 0;
    div_i = 16'd0; prime_lvl_i = 4'd4;
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1; s_data_i = 8'(8'h61 + i);
      @(negedge pclk_i);
    end
    s_valid_i = 0; enable_i = 1;
    while (nl < 4 && t < 20) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL d0_model got=%h exp=%h", dut_vec(), mdl_vec()); end
      if (duty_load_o) begin
        n_chk++; if (duty_o !== 8'(8'h61 + nl)) begin n_fail++; $display("FAIL d0_duty idx=%0d got=%h", nl, duty_o); end
        if (nl > 0) begin
          n_chk++; if (t - last != 1) begin n_fail++; $display("FAIL d0_period got=%0d exp=1", t - last); end
        end
        last = t; nl++;
      end
    end
    n_chk++; if (nl != 4) begin n_fail++; $display("FAIL d0_timeout got=%0d loads exp=4", nl); end
    t = 0;
    while (underrun_cnt_o != 16'hFFFF && t < 70000) begin
      @(negedge pclk_i); t++;
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL sat_model got=%h exp=%h", dut_vec(), mdl_vec()); end
    end
    n_chk++; if (t < 65534 || t >= 70000) begin n_fail++; $display("FAIL sat_cycles got=%0d exp=65535", t); end
    repeat (3) begin
      @(negedge pclk_i);
      n_chk++; if (underrun_cnt_o !== 16'hFFFF || underrun_o !== 1'b1) begin
        n_fail++; $display("FAIL sat_hold got=%h exp=ffff", underrun_cnt_o); end
    end
    flush();
  endtask

  task automatic test_async_reset();
    int t;
    t = 0;
    div_i = 16'd1; prime_lvl_i = 4'd1;
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1; s_data_i = 8'(8'h71 + i);
      @(negedge pclk_i);
    end
    s_valid_i = 0; enable_i = 1;
    while (!duty_load_o && t < 20) begin @(negedge pclk_i); t++; end
    n_chk++; if (!duty_load_o || pwm_rstn_o !== 1'b1) begin n_fail++; $display("FAIL ar_play got=%b/%b exp=1/1", duty_load_o, pwm_rstn_o); end
    @(posedge pclk_i);
    #2 presetn_i = 0;
    #1;
    n_chk++;
    if ({state_o, level_o, duty_o, duty_load_o, pwm_rstn_o, underrun_o, underrun_cnt_o} !== 33'd0) begin
      n_fail++; $display("FAIL ar_async got=%h exp=0", {state_o, level_o, duty_o, pwm_rstn_o});
    end
    @(negedge pclk_i);
    presetn_i = 1; enable_i = 0;
    @(negedge pclk_i);
    n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL ar_model got=%h exp=%h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_random();
    flush();
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk_i);
      n_chk++; if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL rnd_model cyc=%0d got=%h exp=%h", c, dut_vec(), mdl_vec()); end
      s_valid_i  = ($urandom_range(0, 9) < 4);
      s_data_i   = 8'($urandom_range(0, 255));
      soft_rst_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 99) == 0) div_i = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) prime_lvl_i = 4'($urandom_range(0, 8));
    end
    flush();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    mreset();
    presetn_i = 0; enable_i = 0; soft_rst_i = 0; div_i = 16'd0;
    prime_lvl_i = 4'd0; s_valid_i = 0; s_data_i = 8'h00;
    test_reset();
    test_prime_play();
    test_full_fifo();
    test_drain();
    test_abort_flush();
    test_div0_saturate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
